// File: rtl/mult_arbiter.sv
// mult_arbiter: two requesters share one combinational 4x4 multiplier through a
// round-robin IDLE/CALC handshake; operands and products are registered.

module mult #(
  parameter int OP_W = 4
) (
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [2*OP_W-1:0] p
);

  // Array multiplier: accumulate one shifted partial-product row per bit of b
  always_comb begin
    p = {(2*OP_W){1'b0}};
    for (int i = 0; i < OP_W; i++) begin
      p = p + ({{OP_W{1'b0}}, a & {OP_W{b[i]}}} << i);
    end
  end

endmodule

module mult_arbiter #(
  parameter int OP_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic [OP_W-1:0]     opA0,
  input  logic [OP_W-1:0]     opB0,
  output logic                ack0,
  output logic                done0,
  output logic [2*OP_W-1:0]   result0,
  input  logic                req1,
  input  logic [OP_W-1:0]     opA1,
  input  logic [OP_W-1:0]     opB1,
  output logic                ack1,
  output logic                done1,
  output logic [2*OP_W-1:0]   result1,
  output logic                busy
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     opa_q, opa_d;
  logic [OP_W-1:0]     opb_q, opb_d;
  logic                gnt_id_q, gnt_id_d;
  logic                last_q, last_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic [2*OP_W-1:0]   result0_q, result0_d;
  logic [2*OP_W-1:0]   result1_q, result1_d;
  logic                busy_q, busy_d;
  logic [2*OP_W-1:0]   product_s;
  logic                winner_s;

  mult #(.OP_W(OP_W)) u_mult (
    .a (opa_q),
    .b (opb_q),
    .p (product_s)
  );

  // Round-robin pick: a lone request wins, a tie goes to the one not served last
  always_comb begin
    if (req0 && req1) begin
      winner_s = ~last_q;
    end else begin
      winner_s = req1;
    end
  end

  // Next-state and registered-output computation for the IDLE/CALC handshake
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    gnt_id_d  = gnt_id_q;
    last_d    = last_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    result0_d = result0_q;
    result1_d = result1_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          opa_d    = winner_s ? opA1 : opA0;
          opb_d    = winner_s ? opB1 : opB0;
          gnt_id_d = winner_s;
          last_d   = winner_s;
          ack0_d   = ~winner_s;
          ack1_d   = winner_s;
          state_d  = CALC;
        end else begin
          state_d  = IDLE;
        end
      end
      CALC: begin
        // Requests are ignored here; only the granted result register moves
        if (gnt_id_q) begin
          result1_d = product_s;
          done1_d   = 1'b1;
        end else begin
          result0_d = product_s;
          done0_d   = 1'b1;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == CALC);
  end

  // State and output registers; reset discards any in-flight operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opa_q     <= {OP_W{1'b0}};
      opb_q     <= {OP_W{1'b0}};
      gnt_id_q  <= 1'b0;
      last_q    <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      result0_q <= {(2*OP_W){1'b0}};
      result1_q <= {(2*OP_W){1'b0}};
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      gnt_id_q  <= gnt_id_d;
      last_q    <= last_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      result0_q <= result0_d;
      result1_q <= result1_d;
      busy_q    <= busy_d;
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign result0 = result0_q;
  assign result1 = result1_q;
  assign busy    = busy_q;

endmodule
